// File: rtl/spi_register_bridge.sv
// SPI mode-0 slave turning 24-bit host frames into a one-cycle register-write strobe for the synth core.
// Latency: strobe plus Number/Value land SYNC_STAGES+1 i_Clock edges after the 24th SCK rise is first sampled.
// Backpressure: none; the core accepts every strobe, and the SCK-to-i_Clock ratio bounds the frame rate.
//
// Ports: i_Clock / i_Reset_n (async, active-low); i_SPI_SCK, i_SPI_CS_n, i_SPI_MOSI oversampled SPI pins;
//        o_SPI_MISO readback data; o_RegisterWriteEnable, o_RegisterNumber[15:0] (SS PPPPPP OOO VVVVV),
//        o_RegisterValue[7:0] to the synth core; o_FrameError pulses when CS_n rises mid-frame.
// Optional feature macro SPI_READBACK_EN: echo the most recent completed frame on MISO while the next frame shifts.
// SYNC_STAGES must be at least 2.
module spi_register_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_SPI_SCK,
    input  logic        i_SPI_CS_n,
    input  logic        i_SPI_MOSI,
    output logic        o_SPI_MISO,
    output logic        o_RegisterWriteEnable,
    output logic [15:0] o_RegisterNumber,
    output logic [7:0]  o_RegisterValue,
    output logic        o_FrameError
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Synchronizer chains; bit [0] samples the pin, bit [SYNC_STAGES-1] is the usable output.
    // CS_n resets to 0 so a frame already running at reset release never produces a CS_n fall.
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    state_t                 state_q, state_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [23:0]            shift_q, shift_d;
    logic                   frame_done_q, frame_done_d;
    logic                   wr_en_q, wr_en_d;
    logic [15:0]            reg_num_q, reg_num_d;
    logic [7:0]             reg_val_q, reg_val_d;
    logic                   frame_err_q, frame_err_d;

    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, cs_rise, cs_fall;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise = !sck_prev_q && sck_s;
    assign cs_rise  = !cs_prev_q && cs_s;
    assign cs_fall  = cs_prev_q && !cs_s;

`ifdef SPI_READBACK_EN
    // echo holds the last completed frame; tx is the copy being shifted out on MISO.
    logic [23:0] echo_q, echo_d;
    logic [23:0] tx_q, tx_d;
    logic        miso_q, miso_d;
    logic        sck_fall;

    assign sck_fall   = sck_prev_q && !sck_s;
    assign o_SPI_MISO = miso_q;
`else
    assign o_SPI_MISO = 1'b0;
`endif

    assign o_RegisterWriteEnable = wr_en_q;
    assign o_RegisterNumber      = reg_num_q;
    assign o_RegisterValue       = reg_val_q;
    assign o_FrameError          = frame_err_q;

    always_comb begin
        sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], i_SPI_SCK};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS_n};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
        sck_prev_d   = sck_s;
        cs_prev_d    = cs_s;

        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        reg_num_d    = reg_num_q;
        reg_val_d    = reg_val_q;

        // The completed frame is published one cycle after its last bit shifts in,
        // which is what gives the SYNC_STAGES+1 edge latency to the core.
        wr_en_d = frame_done_q;
        if (frame_done_q) begin
            reg_num_d = shift_q[23:8];
            reg_val_d = shift_q[7:0];
        end

`ifdef SPI_READBACK_EN
        echo_d = echo_q;
        tx_d   = tx_q;
        miso_d = miso_q;
        if (frame_done_q) begin
            echo_d = shift_q;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = 5'd0;
`ifdef SPI_READBACK_EN
                miso_d = 1'b0;
`endif
                if (cs_fall) begin
                    state_d = ST_SHIFT;
`ifdef SPI_READBACK_EN
                    tx_d   = echo_q;
                    miso_d = echo_q[23];
`endif
                end
            end
            ST_SHIFT: begin
                // CS_n rise outranks a coincident SCK rise: that last edge is dropped.
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 5'd0;
                    if (bit_cnt_q != 5'd0) begin
                        frame_err_d = 1'b1;
                    end
`ifdef SPI_READBACK_EN
                    miso_d = 1'b0;
`endif
                end else begin
                    if (sck_rise) begin
                        shift_d = {shift_q[22:0], mosi_s};
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d    = 5'd0;
                            frame_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
`ifdef SPI_READBACK_EN
                    // A fall with the counter at 0 follows the 24th rise: the echo register
                    // already holds that frame, so restart the readback from its MSB.
                    if (sck_fall) begin
                        if (bit_cnt_q == 5'd0) begin
                            tx_d   = echo_q;
                            miso_d = echo_q[23];
                        end else begin
                            tx_d   = {tx_q[22:0], 1'b0};
                            miso_d = tx_q[22];
                        end
                    end
`endif
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = 5'd0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sck_sync_q   <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 5'd0;
            shift_q      <= 24'h000000;
            frame_done_q <= 1'b0;
            wr_en_q      <= 1'b0;
            reg_num_q    <= 16'h0000;
            reg_val_q    <= 8'h00;
            frame_err_q  <= 1'b0;
`ifdef SPI_READBACK_EN
            echo_q       <= 24'h000000;
            tx_q         <= 24'h000000;
            miso_q       <= 1'b0;
`endif
        end else begin
            sck_sync_q   <= sck_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sck_prev_q   <= sck_prev_d;
            cs_prev_q    <= cs_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            frame_done_q <= frame_done_d;
            wr_en_q      <= wr_en_d;
            reg_num_q    <= reg_num_d;
            reg_val_q    <= reg_val_d;
            frame_err_q  <= frame_err_d;
`ifdef SPI_READBACK_EN
            echo_q       <= echo_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_register_bridge.sv
// Self-checking bench for spi_register_bridge: SPI host driver, expected-event queue and output monitor.
// Latency: write events are expected SYNC_STAGES+1 i_Clock edges after the 24th SCK rise is first sampled.
// Backpressure: none; the monitor pops one expected event per strobe or error pulse.
module tb_spi_register_bridge;

    localparam int SS   = 2;
    localparam int HALF = 5;   // i_Clock cycles per SCK phase

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        wr_en;
    logic [15:0] reg_num;
    logic [7:0]  reg_val;
    logic        frame_err;

    always #5 clk = ~clk;

    spi_register_bridge #(.SYNC_STAGES(SS)) dut (
        .i_Clock               (clk),
        .i_Reset_n             (rst_n),
        .i_SPI_SCK             (sck),
        .i_SPI_CS_n            (cs_n),
        .i_SPI_MOSI            (mosi),
        .o_SPI_MISO            (miso),
        .o_RegisterWriteEnable (wr_en),
        .o_RegisterNumber      (reg_num),
        .o_RegisterValue       (reg_val),
        .o_FrameError          (frame_err)
    );

    typedef struct {
        bit          is_err;
        logic [15:0] num;
        logic [7:0]  val;
        int          due;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         mon_ev;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] held_num;
    logic [7:0]  held_val;
    logic [23:0] last_full;
    bit          rb_known;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe or error pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", wr_en, 0);
                end else begin
                    mon_ev = exp_q.pop_front();
                    if (mon_ev.is_err) begin
                        check("strobe_where_error_due", wr_en, 0);
                    end else begin
                        check("reg_number", reg_num, mon_ev.num);
                        check("reg_value", reg_val, mon_ev.val);
                        check("strobe_cycle", cyc, mon_ev.due);
                        held_num = mon_ev.num;
                        held_val = mon_ev.val;
                    end
                end
            end
            if (frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_error", frame_err, 0);
                end else begin
                    mon_ev = exp_q.pop_front();
                    if (!mon_ev.is_err) begin
                        check("error_where_strobe_due", frame_err, 0);
                    end else begin
                        check("error_cycle_in_window",
                              (cyc >= mon_ev.due + 2 && cyc <= mon_ev.due + SS + 4) ? 32'd1 : 32'd0, 1);
                        check("number_held_on_error", reg_num, held_num);
                        check("value_held_on_error", reg_val, held_val);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_fall();
        @(negedge clk);
        cs_n = 1'b0;
        idle(HALF);
    endtask

    task automatic cs_rise(input bit err);
        @(negedge clk);
        cs_n = 1'b1;
        if (err) exp_q.push_back('{1'b1, 16'h0000, 8'h00, cyc});
        idle(4 * HALF);
    endtask

    // Shift the first n bits of f (MSB first); rx collects MISO sampled just before each rise.
    task automatic send_bits(input logic [23:0] f, input int n, input bit full, output logic [23:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            mosi = f[23 - i];
            idle(HALF);
            rx[23 - i] = miso;
            sck = 1'b1;
            if (full && i == 23) exp_q.push_back('{1'b0, f[23:8], f[7:0], cyc + SS + 2});
            idle(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [23:0] f);
        logic [23:0] rx;
`ifdef SPI_READBACK_EN
        logic [23:0] exp_rb;
        bit          known;
        exp_rb = last_full;
        known  = rb_known;
`endif
        send_bits(f, 24, 1'b1, rx);
`ifdef SPI_READBACK_EN
        if (known) check("miso_readback", rx, exp_rb);
`else
        check("miso_stays_zero", rx, 0);
`endif
        last_full = f;
        rb_known  = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobe"}, wr_en, 0);
        check({tag, "_number"}, reg_num, 0);
        check({tag, "_value"}, reg_val, 0);
        check({tag, "_frame_error"}, frame_err, 0);
        check({tag, "_miso"}, miso, 0);
    endtask

    logic [23:0] rx_dummy;
    logic [23:0] rnd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d events pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        sck       = 1'b0;
        cs_n      = 1'b1;
        mosi      = 1'b0;
        held_num  = 16'h0000;
        held_val  = 8'h00;
        last_full = 24'h000000;
        rb_known  = 1'b0;
        idle(3);
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(4 * HALF);

        // Single frame.
        cs_fall();
        send_frame(24'hC0057F);
        cs_rise(1'b0);

        // Burst of two frames in one CS_n assertion.
        cs_fall();
        send_frame(24'h800103);
        send_frame(24'hC221AA);
        cs_rise(1'b0);

        // Aborted frame after 13 bits, then a normal frame.
        cs_fall();
        rnd = 24'($urandom);
        send_bits(rnd, 13, 1'b0, rx_dummy);
        cs_rise(1'b1);
        check("abort_keeps_number", reg_num, 16'hC221);
        check("abort_keeps_value", reg_val, 8'hAA);
        cs_fall();
        send_frame(24'h800001);
        cs_rise(1'b0);

        // Reset mid-frame with CS_n held low; the resumed bits must be ignored.
        cs_fall();
        send_bits(24'h5A5A5A, 10, 1'b0, rx_dummy);
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        check_reset_outputs("midframe_reset");
        held_num  = 16'h0000;
        held_val  = 8'h00;
        last_full = 24'h000000;
        rb_known  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_bits(24'($urandom), 14, 1'b0, rx_dummy);
        cs_rise(1'b0);
        check("after_reset_number_zero", reg_num, 0);
        cs_fall();
        send_frame(24'hC10342);
        cs_rise(1'b0);

        // Priority: 24th SCK rise coincident with CS_n rise is dropped -> error, no strobe.
        cs_fall();
        rnd = 24'($urandom);
        send_bits(rnd, 23, 1'b0, rx_dummy);
        mosi = rnd[0];
        idle(HALF);
        sck  = 1'b1;
        cs_n = 1'b1;
        exp_q.push_back('{1'b1, 16'h0000, 8'h00, cyc});
        idle(HALF);
        sck = 1'b0;
        idle(4 * HALF);

        // Priority: extra SCK rise coincident with CS_n rise after a full frame -> no error.
        cs_fall();
        send_frame(24'h8A0B0C);
        mosi = 1'b1;
        idle(HALF);
        sck  = 1'b1;
        cs_n = 1'b1;
        idle(HALF);
        sck = 1'b0;
        idle(4 * HALF);

        // Readback burst.
        cs_fall();
        send_frame(24'h123456);
        send_frame(24'hABCDEF);
        cs_rise(1'b0);

        // Randomized sessions: full bursts or aborted partial frames.
        for (int s = 0; s < 14; s++) begin
            cs_fall();
            if ($urandom_range(0, 3) == 0) begin
                rnd = 24'($urandom);
                send_bits(rnd, int'($urandom_range(1, 23)), 1'b0, rx_dummy);
                cs_rise(1'b1);
            end else begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    send_frame(24'($urandom));
                end
                cs_rise(1'b0);
            end
        end

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        check("pending_events", exp_q.size(), 0);
        check("final_number_held", reg_num, held_num);
        check("final_value_held", reg_val, held_val);
        check("final_miso_idle", miso, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
